cla_pipe_adder: RTL and testbench

//  Parametrised, pipelined carry-lookahead add/subtract unit; successor of the fixed 16-bit CLA.

---
 rtl/cla_pkg.sv | 16 +
 rtl/cla_pipe_adder_if.sv | 31 +++
 rtl/cla_segment.sv | 88 ++++++++
 rtl/cla_pipe_adder.sv | 107 ++++++++++
 tb/tb_cla_pipe_adder.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cla_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cla_pkg : shared constants and configuration check for the CLA pipeline    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package cla_pkg;

  localparam int c_GRP_W = 4;

  function automatic bit is_legal_seg(input int width, input int seg_w);
    return (seg_w >= c_GRP_W) && ((seg_w % c_GRP_W) == 0) &&
           (width >= seg_w) && ((width % seg_w) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cla_pipe_adder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cla_pipe_adder_if : operand/result valid-ready streams of the adder        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface cla_pipe_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface
`default_nettype wire

// File: rtl/cla_segment.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cla_segment : combinational SEG_W-bit adder, 4-bit groups, group lookahead |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module cla_segment
  import cla_pkg::*;
#(
  parameter int SEG_W = 16
) (
  input  logic [SEG_W-1:0] a_i,
  input  logic [SEG_W-1:0] b_i,
  input  logic             cin_i,
  output logic [SEG_W-1:0] sum_o,
  output logic             cout_o,
  output logic             c_msb_o
);

  localparam int NGRP = SEG_W / c_GRP_W;

  // Carry into position n as a flat sum of products: no term depends on another carry.
  function automatic logic lookahead(input logic [SEG_W-1:0] g, input logic [SEG_W-1:0] p,
                                     input logic c0, input int n);
    logic res;
    logic term;
    res  = c0;
    term = 1'b0;
    for (int m = 0; m < SEG_W; m++) begin
      if (m < n) res = res & p[m];
    end
    for (int i = 0; i < SEG_W; i++) begin
      if (i < n) begin
        term = g[i];
        for (int m = 0; m < SEG_W; m++) begin
          if ((m > i) && (m < n)) term = term & p[m];
        end
        res = res | term;
      end
    end
    return res;
  endfunction

  logic [SEG_W-1:0] w_p;
  logic [SEG_W-1:0] w_g;
  logic [SEG_W-1:0] w_c;
  logic [SEG_W-1:0] w_grp_p;
  logic [SEG_W-1:0] w_grp_g;
  logic [NGRP:0]    w_grp_c;

  always_comb begin
    logic [SEG_W-1:0] tp;
    logic [SEG_W-1:0] tg;
    w_p     = a_i ^ b_i;
    w_g     = a_i & b_i;
    w_grp_p = '0;
    w_grp_g = '0;
    w_grp_c = '0;
    w_c     = '0;
    tp      = '0;
    tg      = '0;
    for (int j = 0; j < NGRP; j++) begin
      tp = '0;
      tg = '0;
      tp[c_GRP_W-1:0] = w_p[j*c_GRP_W +: c_GRP_W];
      tg[c_GRP_W-1:0] = w_g[j*c_GRP_W +: c_GRP_W];
      w_grp_p[j] = &tp[c_GRP_W-1:0];
      w_grp_g[j] = lookahead(tg, tp, 1'b0, c_GRP_W);
    end
    for (int j = 0; j <= NGRP; j++) begin
      w_grp_c[j] = lookahead(w_grp_g, w_grp_p, cin_i, j);
    end
    for (int j = 0; j < NGRP; j++) begin
      tp = '0;
      tg = '0;
      tp[c_GRP_W-1:0] = w_p[j*c_GRP_W +: c_GRP_W];
      tg[c_GRP_W-1:0] = w_g[j*c_GRP_W +: c_GRP_W];
      for (int b = 0; b < c_GRP_W; b++) begin
        w_c[j*c_GRP_W + b] = lookahead(tg, tp, w_grp_c[j], b);
      end
    end
  end

  assign sum_o   = w_p ^ w_c;
  assign cout_o  = w_grp_c[NGRP];
  assign c_msb_o = w_c[SEG_W-1];

endmodule
`default_nettype wire

// File: rtl/cla_pipe_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cla_pipe_adder : pipelined add/subtract, one SEG_W segment per stage       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  cla_pipe_adder_if.slave bus
);

  localparam int NSEG = WIDTH / SEG_W;

  if (!is_legal_seg(WIDTH, SEG_W)) begin : g_bad_cfg
    $error("cla_pipe_adder: WIDTH must be a multiple of SEG_W and SEG_W a multiple of 4");
  end

  logic             w_adv;
  logic             w_c0;
  logic [WIDTH-1:0] w_b_eff;

  logic             vld_q [NSEG];
  logic [WIDTH-1:0] a_q   [NSEG];
  logic [WIDTH-1:0] b_q   [NSEG];
  logic [WIDTH-1:0] sum_q [NSEG];
  logic             cy_q  [NSEG];
  logic             ovf_q [NSEG];

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign w_adv        = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  assign w_b_eff = bus.in_sub ? ~bus.in_b : bus.in_b;
  assign w_c0    = bus.in_sub | bus.in_cin;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    logic             w_vin;
    logic             w_cin;
    logic             w_cout;
    logic             w_cmsb;
    logic [WIDTH-1:0] w_ain;
    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_sin;
    logic [WIDTH-1:0] sum_d;
    logic [SEG_W-1:0] w_seg_sum;

    if (k == 0) begin : g_first
      assign w_vin = bus.in_valid;
      assign w_cin = w_c0;
      assign w_ain = bus.in_a;
      assign w_bin = w_b_eff;
      assign w_sin = '0;
    end else begin : g_next
      assign w_vin = vld_q[k-1];
      assign w_cin = cy_q[k-1];
      assign w_ain = a_q[k-1];
      assign w_bin = b_q[k-1];
      assign w_sin = sum_q[k-1];
    end

    cla_segment #(
      .SEG_W (SEG_W)
    ) u_seg (
      .a_i     (w_ain[k*SEG_W +: SEG_W]),
      .b_i     (w_bin[k*SEG_W +: SEG_W]),
      .cin_i   (w_cin),
      .sum_o   (w_seg_sum),
      .cout_o  (w_cout),
      .c_msb_o (w_cmsb)
    );

    always_comb begin
      sum_d                   = w_sin;
      sum_d[k*SEG_W +: SEG_W] = w_seg_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
        cy_q[k]  <= 1'b0;
        ovf_q[k] <= 1'b0;
      end else if (w_adv) begin
        vld_q[k] <= w_vin;
        a_q[k]   <= w_ain;
        b_q[k]   <= w_bin;
        sum_q[k] <= sum_d;
        cy_q[k]  <= w_cout;
        ovf_q[k] <= w_cout ^ w_cmsb;
      end
    end
  end

  assign bus.out_valid = vld_q[NSEG-1];
  assign bus.out_sum   = sum_q[NSEG-1];
  assign bus.out_cout  = cy_q[NSEG-1];
  assign bus.out_ovf   = ovf_q[NSEG-1];

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cla_pipe_adder : scoreboard bench for cla_pipe_adder (32/64/16 configs) |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_cla_pipe_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cla_pipe_adder_if #(.WIDTH(32)) bus ();
  cla_pipe_adder_if #(.WIDTH(64)) bus64 ();
  cla_pipe_adder_if #(.WIDTH(16)) bus16 ();

  cla_pipe_adder #(.WIDTH(32), .SEG_W(16)) dut   (.clk(clk), .rst(rst), .bus(bus));
  cla_pipe_adder #(.WIDTH(64), .SEG_W(16)) dut64 (.clk(clk), .rst(rst), .bus(bus64));
  cla_pipe_adder #(.WIDTH(16), .SEG_W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   pops = 0;
  int   stall_cnt = 0;
  int   cyc = 0;
  logic held_v = 1'b0;
  exp_t held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    logic [31:0] be;
    logic [32:0] t;
    exp_t        e;
    be     = sub ? ~b : b;
    t      = {1'b0, a} + {1'b0, be} + {32'b0, (sub ? 1'b1 : cin)};
    e.sum  = t[31:0];
    e.cout = t[32];
    e.ovf  = (a[31] == be[31]) && (t[31] != a[31]);
    return e;
  endfunction

  // Output monitor: pops the scoreboard on every transfer, checks stability while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_sum", bus.out_sum, held.sum);
        check("hold_cout", bus.out_cout, held.cout);
        check("hold_ovf", bus.out_ovf, held.ovf);
      end
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          held_v = 1'b0;
          if (sbq.size() == 0) begin
            check("unexpected_out", bus.out_valid, 0);
          end else begin
            e = sbq.pop_front();
            pops++;
            check("out_sum", bus.out_sum, e.sum);
            check("out_cout", bus.out_cout, e.cout);
            check("out_ovf", bus.out_ovf, e.ovf);
          end
        end else begin
          held_v = 1'b1;
          held   = {bus.out_sum, bus.out_cout, bus.out_ovf};
          stall_cnt++;
          check("stall_in_ready", bus.in_ready, 0);
        end
      end else begin
        held_v = 1'b0;
        check("idle_in_ready", bus.in_ready, 1);
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input logic sub, input exp_t e);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_sub   = sub;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sbq.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    check("send_timeout", bus.in_ready, 1);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          p0;
    int          c0;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic        rs;

    rst = 1'b1;
    bus.in_valid = 1'b0;   bus.in_a = '0;   bus.in_b = '0;   bus.in_cin = 1'b0;
    bus.in_sub = 1'b0;     bus.out_ready = 1'b1;
    bus64.in_valid = 1'b0; bus64.in_a = '0; bus64.in_b = '0; bus64.in_cin = 1'b0;
    bus64.in_sub = 1'b0;   bus64.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.in_a = '0; bus16.in_b = '0; bus16.in_cin = 1'b0;
    bus16.in_sub = 1'b0;   bus16.out_ready = 1'b1;

    #12;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sum", bus.out_sum, 0);
    check("rst_out_cout", bus.out_cout, 0);
    check("rst_out_ovf", bus.out_ovf, 0);
    check("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Latency: cycles from the beat being presented until its result is visible.
    send(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, '{32'h00010000, 1'b0, 1'b0});
    n = 1;
    while (!bus.out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("lat32", n, 2);
    @(posedge clk);
    #1;

    bus64.in_a = 64'h0000_0000_0000_FFFF; bus64.in_b = 64'h1; bus64.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus64.in_valid = 1'b0;
    n = 1;
    while (!bus64.out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("lat64", n, 4);
    check("sum64", bus64.out_sum, 64'h0000_0000_0001_0000);
    check("cout64", bus64.out_cout, 0);
    @(posedge clk);
    #1;
    check("single64", bus64.out_valid, 0);

    bus16.in_a = 16'hFFFF; bus16.in_b = 16'h0001; bus16.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus16.in_valid = 1'b0;
    n = 1;
    while (!bus16.out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("lat16", n, 1);
    check("sum16", bus16.out_sum, 16'h0000);
    check("cout16", bus16.out_cout, 1);
    check("ovf16", bus16.out_ovf, 0);

    send(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, '{32'h00000000, 1'b1, 1'b0});
    send(32'h00000005, 32'h00000007, 1'b0, 1'b1, '{32'hFFFFFFFE, 1'b0, 1'b0});
    send(32'h80000000, 32'h00000001, 1'b0, 1'b1, '{32'h7FFFFFFF, 1'b1, 1'b1});
    send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, '{32'h80000000, 1'b0, 1'b1});
    repeat (4) @(posedge clk);
    #1;
    check("directed_drain", sbq.size(), 0);

    p0 = pops;
    c0 = cyc;
    for (int i = 0; i < 100; i++) begin
      ra = $urandom; rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      send(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end
    check("stream_cycles", cyc - c0, 100);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("stream_count", pops - p0, 100);

    stall_cnt = 0;
    p0 = pops;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          ra = $urandom; rb = $urandom;
          rc = 1'($urandom_range(0, 1));
          rs = 1'($urandom_range(0, 1));
          send(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 20; i++) begin
      if (sbq.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("bp_drain", sbq.size(), 0);
    check("bp_count", pops - p0, 30);
    check("bp_stall_cycles", stall_cnt, 5);

    bus.out_ready = 1'b0;
    send(32'h11111111, 32'h22222222, 1'b0, 1'b0, model(32'h11111111, 32'h22222222, 1'b0, 1'b0));
    send(32'h33333333, 32'h44444444, 1'b1, 1'b0, model(32'h33333333, 32'h44444444, 1'b1, 1'b0));
    check("inflight_valid", bus.out_valid, 1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", bus.out_valid, 0);
    check("async_rst_sum", bus.out_sum, 0);
    check("async_rst_cout", bus.out_cout, 0);
    check("async_rst_ovf", bus.out_ovf, 0);
    sbq.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("post_rst_quiet", bus.out_valid, 0);
    end

    send(32'h00000005, 32'h00000007, 1'b0, 1'b1, '{32'hFFFFFFFE, 1'b0, 1'b0});
    repeat (4) @(posedge clk);
    #1;
    check("final_sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
